// File: rtl/ime_sad_decision_pkg.sv
// Shared definitions for the IME SAD decision block.
// Widths, partition field indices (packed-output order) and the FSM state type.
// Also a helper that widens one 4x4 SAD to the partition SAD width.
package ime_sad_decision_pkg;

    localparam int SAD4X4_LEN = 12;
    localparam int SAD4X4_NUM = 16;
    localparam int PART_NUM   = 9;
    localparam int MV_W       = 8;
    localparam int SADP_LEN   = SAD4X4_LEN + 4;

    // Field index of each partition in best_sad_o / best_mv_o.
    localparam int P8X8_0  = 0;
    localparam int P8X8_1  = 1;
    localparam int P8X8_2  = 2;
    localparam int P8X8_3  = 3;
    localparam int P16X8_T = 4;
    localparam int P16X8_B = 5;
    localparam int P8X16_L = 6;
    localparam int P8X16_R = 7;
    localparam int P16X16  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StDrain
    } state_t;

    function automatic logic [SADP_LEN-1:0] zext_sad4(input logic [SAD4X4_LEN-1:0] v);
        return SADP_LEN'(v);
    endfunction

endpackage

// File: rtl/ime_sad_merge.sv
// Combinational 16 -> 9 partition adder tree.
// Ports:
//   sad4x4   - 16 packed 4x4 SADs, index k = i*4 + j (i = 8x8 block, j = 4x4 inside it)
//   sad_part - 9 packed partition SADs in partition field order
// SADP_LEN leaves enough headroom that none of the sums can wrap.
module ime_sad_merge
    import ime_sad_decision_pkg::*;
(
    input  logic [SAD4X4_NUM*SAD4X4_LEN-1:0] sad4x4,
    output logic [PART_NUM*SADP_LEN-1:0]     sad_part
);

    logic [SADP_LEN-1:0] b8 [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            b8[i] = '0;
            for (int j = 0; j < 4; j++) begin
                b8[i] = b8[i] + zext_sad4(sad4x4[(4*i+j)*SAD4X4_LEN +: SAD4X4_LEN]);
            end
        end
    end

    always_comb begin
        sad_part = '0;
        sad_part[P8X8_0*SADP_LEN  +: SADP_LEN] = b8[0];
        sad_part[P8X8_1*SADP_LEN  +: SADP_LEN] = b8[1];
        sad_part[P8X8_2*SADP_LEN  +: SADP_LEN] = b8[2];
        sad_part[P8X8_3*SADP_LEN  +: SADP_LEN] = b8[3];
        sad_part[P16X8_T*SADP_LEN +: SADP_LEN] = b8[0] + b8[1];
        sad_part[P16X8_B*SADP_LEN +: SADP_LEN] = b8[2] + b8[3];
        sad_part[P8X16_L*SADP_LEN +: SADP_LEN] = b8[0] + b8[2];
        sad_part[P8X16_R*SADP_LEN +: SADP_LEN] = b8[1] + b8[3];
        sad_part[P16X16*SADP_LEN  +: SADP_LEN] = b8[0] + b8[1] + b8[2] + b8[3];
    end

endmodule

// File: rtl/ime_sad_decision.sv
// IME SAD decision: merges each candidate's 16 4x4 SADs into 9 partition SADs
// and keeps the per-partition minimum SAD and its MV over one MB search window.
// Ports:
//   clk, rstn   - clock, asynchronous active-low reset
//   start_i     - begin a new search (honoured only when idle)
//   valid_i     - candidate present on sad4x4_i / mv_*_i (honoured only while searching)
//   last_i      - with valid_i: final candidate of the window
//   sad4x4_i    - 16 packed 4x4 SADs
//   mv_x_i/y_i  - signed candidate MV
//   busy_o      - search in progress
//   done_o      - one-cycle pulse, best_* final
//   best_sad_o  - 9 packed partition minima
//   best_mv_o   - 9 packed {mv_y, mv_x}, same order
// Two-stage pipeline: stage 1 registers the merged sums, stage 2 compares/updates.
module ime_sad_decision
    import ime_sad_decision_pkg::*;
(
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             start_i,
    input  logic                             valid_i,
    input  logic                             last_i,
    input  logic [SAD4X4_NUM*SAD4X4_LEN-1:0] sad4x4_i,
    input  logic signed [MV_W-1:0]           mv_x_i,
    input  logic signed [MV_W-1:0]           mv_y_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [PART_NUM*SADP_LEN-1:0]     best_sad_o,
    output logic [PART_NUM*2*MV_W-1:0]       best_mv_o
);

    state_t state_q, state_d;

    logic                         accept;
    logic                         init_best;
    logic [PART_NUM*SADP_LEN-1:0] merged;

    logic                         s1_valid_q;
    logic [PART_NUM*SADP_LEN-1:0] s1_sad_q;
    logic [2*MV_W-1:0]            s1_mv_q;

    assign accept    = (state_q == StSearch) && valid_i;
    assign init_best = (state_q == StIdle) && start_i;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StSearch;
                end
            end
            StSearch: begin
                busy_o = 1'b1;
                if (valid_i && last_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Once stage 1 is empty the last beat has reached the best registers.
                if (!s1_valid_q) begin
                    done_o  = 1'b1;
                    state_d = StIdle;
                end else begin
                    busy_o = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------- Stage 1: merge ----------------
    ime_sad_merge u_merge (
        .sad4x4   (sad4x4_i),
        .sad_part (merged)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_sad_q   <= '0;
            s1_mv_q    <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_sad_q <= merged;
                s1_mv_q  <= {mv_y_i, mv_x_i};
            end
        end
    end

    // ---------------- Stage 2: per-partition compare/update ----------------
    for (genvar p = 0; p < PART_NUM; p++) begin : g_part
        logic [SADP_LEN-1:0] cand;
        logic [SADP_LEN-1:0] best_sad_q;
        logic [2*MV_W-1:0]   best_mv_q;
        logic                upd;

        assign cand = s1_sad_q[p*SADP_LEN +: SADP_LEN];
        // Strict less-than: on a tie the earlier candidate is kept.
        assign upd  = s1_valid_q && (cand < best_sad_q);

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                best_sad_q <= '0;
                best_mv_q  <= '0;
            end else if (init_best) begin
                best_sad_q <= '1;
                best_mv_q  <= '0;
            end else if (upd) begin
                best_sad_q <= cand;
                best_mv_q  <= s1_mv_q;
            end
        end

        assign best_sad_o[p*SADP_LEN +: SADP_LEN] = best_sad_q;
        assign best_mv_o[p*2*MV_W +: 2*MV_W]      = best_mv_q;
    end

endmodule

// File: tb/tb_ime_sad_decision.sv
// Self-checking bench for ime_sad_decision: a window/beat model computes the expected
// busy/done/best_* on every cycle; literal checks pin the model on directed windows.
module tb_ime_sad_decision;
    import ime_sad_decision_pkg::*;

    localparam int SW = SAD4X4_NUM * SAD4X4_LEN;
    localparam int PW = PART_NUM * SADP_LEN;
    localparam int MW = PART_NUM * 2 * MV_W;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic                    start_i = 1'b0;
    logic                    valid_i = 1'b0;
    logic                    last_i = 1'b0;
    logic [SW-1:0]           sad4x4_i = '0;
    logic signed [MV_W-1:0]  mv_x_i = '0;
    logic signed [MV_W-1:0]  mv_y_i = '0;
    logic                    busy_o;
    logic                    done_o;
    logic [PW-1:0]           best_sad_o;
    logic [MW-1:0]           best_mv_o;

    ime_sad_decision dut (
        .clk        (clk),
        .rstn       (rstn),
        .start_i    (start_i),
        .valid_i    (valid_i),
        .last_i     (last_i),
        .sad4x4_i   (sad4x4_i),
        .mv_x_i     (mv_x_i),
        .mv_y_i     (mv_y_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .best_sad_o (best_sad_o),
        .best_mv_o  (best_mv_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct packed {
        int                cyc;
        int                win;
        logic [PW-1:0]     part;
        logic [2*MV_W-1:0] mv;
    } beat_t;

    beat_t beats[$];
    int    win_start[$];
    int    win_done[$];
    bit    chk_en = 1'b0;
    int    checks = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // Partition SADs straight from the block geometry.
    function automatic logic [PW-1:0] model_parts(input logic [SW-1:0] v);
        int unsigned   b[4];
        int unsigned   p[9];
        logic [PW-1:0] r;
        for (int i = 0; i < 4; i++) begin
            b[i] = 0;
            for (int j = 0; j < 4; j++) b[i] += 32'(v[(4*i+j)*SAD4X4_LEN +: SAD4X4_LEN]);
        end
        p[0] = b[0]; p[1] = b[1]; p[2] = b[2]; p[3] = b[3];
        p[4] = b[0] + b[1]; p[5] = b[2] + b[3];
        p[6] = b[0] + b[2]; p[7] = b[1] + b[3];
        p[8] = b[0] + b[1] + b[2] + b[3];
        for (int k = 0; k < 9; k++) r[k*SADP_LEN +: SADP_LEN] = 16'(p[k]);
        return r;
    endfunction

    // Per-cycle comparison against the window model.
    always @(negedge clk) begin
        if (chk_en && rstn) begin
            int            w;
            logic [PW-1:0] es;
            logic [MW-1:0] em;
            logic          ed;
            logic          eb;
            w = -1;
            for (int i = win_start.size() - 1; i >= 0; i--) begin
                if (w < 0 && win_start[i] < cyc) w = i;
            end
            es = '0; em = '0; ed = 1'b0; eb = 1'b0;
            if (w >= 0) begin
                es = '1;
                foreach (beats[b]) begin
                    if (beats[b].win == w && beats[b].cyc <= cyc - 2) begin
                        for (int p = 0; p < PART_NUM; p++) begin
                            if (beats[b].part[p*SADP_LEN +: SADP_LEN] < es[p*SADP_LEN +: SADP_LEN]) begin
                                es[p*SADP_LEN +: SADP_LEN] = beats[b].part[p*SADP_LEN +: SADP_LEN];
                                em[p*2*MV_W +: 2*MV_W]     = beats[b].mv;
                            end
                        end
                    end
                end
                ed = (win_done[w] == cyc);
                eb = (win_done[w] < 0) || (cyc < win_done[w]);
            end
            check("done_o", 32'(done_o), 32'(ed));
            check("busy_o", 32'(busy_o), 32'(eb));
            for (int p = 0; p < PART_NUM; p++) begin
                check($sformatf("best_sad[%0d]", p), 32'(best_sad_o[p*SADP_LEN +: SADP_LEN]),
                      32'(es[p*SADP_LEN +: SADP_LEN]));
                check($sformatf("best_mv[%0d]", p), 32'(best_mv_o[p*2*MV_W +: 2*MV_W]),
                      32'(em[p*2*MV_W +: 2*MV_W]));
            end
        end
    end

    function automatic logic [SW-1:0] uni(input int unsigned val);
        logic [SW-1:0] v;
        for (int k = 0; k < SAD4X4_NUM; k++) v[k*SAD4X4_LEN +: SAD4X4_LEN] = 12'(val);
        return v;
    endfunction

    function automatic logic [SW-1:0] rvec(input int unsigned maxv);
        logic [SW-1:0] v;
        for (int k = 0; k < SAD4X4_NUM; k++) v[k*SAD4X4_LEN +: SAD4X4_LEN] = 12'($urandom_range(0, maxv));
        return v;
    endfunction

    function automatic int rmv();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic drive(input bit s, input bit v, input bit l, input logic [SW-1:0] d,
                         input int mx, input int my);
        @(posedge clk);
        #1;
        start_i  = s;
        valid_i  = v;
        last_i   = l;
        sad4x4_i = d;
        mv_x_i   = MV_W'(mx);
        mv_y_i   = MV_W'(my);
    endtask

    task automatic new_window();
        drive(1'b1, 1'b0, rbit(), rvec(4080), rmv(), rmv());
        win_start.push_back(cyc);
        win_done.push_back(-1);
    endtask

    // sj drives a stray start_i alongside the beat; it must be ignored in SEARCH.
    task automatic beat(input logic [SW-1:0] d, input int mx, input int my, input bit l,
                        input bit sj);
        beat_t bt;
        drive(sj, 1'b1, l, d, mx, my);
        bt.cyc  = cyc;
        bt.win  = win_start.size() - 1;
        bt.part = model_parts(d);
        bt.mv   = {MV_W'(my), MV_W'(mx)};
        beats.push_back(bt);
        if (l) win_done[win_done.size() - 1] = cyc + 2;
    endtask

    task automatic gap(input bit sj);
        drive(sj, 1'b0, rbit(), rvec(4080), rmv(), rmv());
    endtask

    // Stray valid in DRAIN, stray start coinciding with done; both ignored.
    task automatic close_window();
        drive(1'b0, 1'b1, 1'b1, rvec(3), rmv(), rmv());
        drive(1'b1, 1'b0, 1'b0, rvec(3), rmv(), rmv());
        @(negedge clk);
        check("done_two_after_last", 32'(done_o), 32'd1);
        check("busy_low_at_done", 32'(busy_o), 32'd0);
    endtask

    task automatic lit_sad(input string name, input int p, input int unsigned exp);
        check(name, 32'(best_sad_o[p*SADP_LEN +: SADP_LEN]), exp);
    endtask

    task automatic lit_mv(input string name, input int p, input int mx, input int my);
        logic [2*MV_W-1:0] e;
        e = {MV_W'(my), MV_W'(mx)};
        check(name, 32'(best_mv_o[p*2*MV_W +: 2*MV_W]), 32'(e));
    endtask

    initial begin
        logic [SW-1:0] va;
        logic [SW-1:0] vb;

        #1;
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_sad_zero", 32'(best_sad_o == '0), 32'd1);
        check("reset_mv_zero", 32'(best_mv_o == '0), 32'd1);
        @(posedge clk);
        #1;
        rstn   = 1'b1;
        chk_en = 1'b1;
        gap(1'b0);

        // Single candidate.
        new_window();
        beat(uni(1), 3, -2, 1'b1, 1'b0);
        close_window();
        lit_sad("single_8x8_0", P8X8_0, 4);
        lit_sad("single_8x8_3", P8X8_3, 4);
        lit_sad("single_16x8_t", P16X8_T, 8);
        lit_sad("single_8x16_r", P8X16_R, 8);
        lit_sad("single_16x16", P16X16, 16);
        lit_mv("single_mv_16x16", P16X16, 3, -2);
        lit_mv("single_mv_8x8_2", P8X8_2, 3, -2);

        // Three back-to-back candidates.
        new_window();
        beat(uni(10), 0, 0, 1'b0, 1'b0);
        beat(uni(5), 1, 1, 1'b0, 1'b0);
        beat(uni(7), 2, 2, 1'b1, 1'b0);
        close_window();
        lit_sad("three_8x8_1", P8X8_1, 20);
        lit_sad("three_16x8_b", P16X8_B, 40);
        lit_sad("three_16x16", P16X16, 80);
        lit_mv("three_mv_16x16", P16X16, 1, 1);
        lit_mv("three_mv_8x16_l", P8X16_L, 1, 1);

        // Tie: earlier candidate wins.
        new_window();
        beat(uni(20), 4, 0, 1'b0, 1'b0);
        beat(uni(20), -4, 0, 1'b1, 1'b0);
        close_window();
        lit_sad("tie_16x16", P16X16, 320);
        lit_mv("tie_mv_16x16", P16X16, 4, 0);
        lit_mv("tie_mv_8x8_3", P8X8_3, 4, 0);

        // Per-partition independence.
        va = uni(100);
        vb = uni(100);
        for (int j = 0; j < 4; j++) begin
            va[j*SAD4X4_LEN +: SAD4X4_LEN]      = '0;
            vb[(12+j)*SAD4X4_LEN +: SAD4X4_LEN] = '0;
        end
        new_window();
        beat(va, 5, 6, 1'b0, 1'b0);
        beat(vb, -7, -8, 1'b1, 1'b0);
        close_window();
        lit_sad("indep_8x8_0", P8X8_0, 0);
        lit_sad("indep_8x8_3", P8X8_3, 0);
        lit_sad("indep_16x16", P16X16, 1200);
        lit_mv("indep_mv_8x8_0", P8X8_0, 5, 6);
        lit_mv("indep_mv_8x8_3", P8X8_3, -7, -8);
        lit_mv("indep_mv_16x16", P16X16, 5, 6);
        lit_mv("indep_mv_16x8_t", P16X8_T, 5, 6);
        lit_mv("indep_mv_16x8_b", P16X8_B, -7, -8);

        // Maximum values: no wrap.
        new_window();
        beat(uni(4080), -128, 127, 1'b1, 1'b0);
        close_window();
        lit_sad("max_16x16", P16X16, 65280);
        lit_sad("max_16x8_t", P16X8_T, 32640);
        lit_sad("max_8x8_2", P8X8_2, 16320);

        // Start during SEARCH must not reinit: 1s then stray start then 2s.
        new_window();
        beat(uni(1), 9, 9, 1'b0, 1'b0);
        gap(1'b1);
        beat(uni(2), 8, 8, 1'b1, 1'b1);
        close_window();
        lit_sad("nostart_16x16", P16X16, 16);
        lit_mv("nostart_mv_16x16", P16X16, 9, 9);

        // Randomized windows with gaps, stray starts and idle stray valids.
        for (int w = 0; w < 40; w++) begin
            int          nb;
            int unsigned maxv;
            maxv = (w % 3 == 0) ? 3 : 4080;
            if (rbit()) drive(1'b0, 1'b1, rbit(), rvec(2), rmv(), rmv());
            new_window();
            nb = int'($urandom_range(1, 10));
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) gap(rbit());
                beat(rvec(maxv), rmv(), rmv(), b == nb - 1, ($urandom_range(0, 7) == 0));
            end
            close_window();
        end

        // Reset mid-SEARCH after two beats.
        new_window();
        beat(uni(9), 1, 2, 1'b0, 1'b0);
        beat(uni(9), 3, 4, 1'b0, 1'b0);
        @(negedge clk);
        chk_en  = 1'b0;
        rstn    = 1'b0;
        start_i = 1'b0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        beats.delete();
        win_start.delete();
        win_done.delete();
        #1;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_done", 32'(done_o), 32'd0);
        check("midrst_sad_zero", 32'(best_sad_o == '0), 32'd1);
        check("midrst_mv_zero", 32'(best_mv_o == '0), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rstn   = 1'b1;
        chk_en = 1'b1;
        // Stray valids while idle; the model expects nothing to change.
        repeat (4) drive(1'b0, 1'b1, 1'b1, rvec(3), rmv(), rmv());
        new_window();
        beat(uni(2), -1, 1, 1'b1, 1'b0);
        close_window();
        lit_sad("after_rst_16x16", P16X16, 32);
        lit_sad("after_rst_8x8_1", P8X8_1, 8);
        lit_mv("after_rst_mv", P16X16, -1, 1);

        repeat (4) gap(1'b0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ime_sad_decision.md
Name: ime_sad_decision

Overview:
- Consumer of the per-search-point 4x4 SAD vector produced by the IME 4x4 SAD array.
- Merges the 16 4x4 SADs of each candidate into 9 partition SADs: 8x8 x4, 16x8 x2, 8x16 x2, 16x16 x1.
- Tracks the minimum SAD and its motion vector per partition across one macroblock search window.
- Reports the winners to the mode decision / FME stage with a done pulse.

Parameters:
- SAD4X4_LEN, 12, width of one 4x4 SAD (16*255 = 4080 max).
- SAD4X4_NUM, 16, number of 4x4 SADs per candidate.
- PART_NUM, 9, number of tracked partitions.
- MV_W, 8, width of each signed integer MV component.
- SADP_LEN, SAD4X4_LEN+4, width of every packed partition SAD output field.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start_i  in  1  begin new MB search; 1-cycle pulse
- valid_i  in  1  sad4x4_i/mv_*_i hold one candidate this cycle
- last_i  in  1  qualifies valid_i: final candidate of the window
- sad4x4_i  in  SAD4X4_NUM*SAD4X4_LEN  16 SADs; index k=i*4+j, i = 8x8 block (raster), j = 4x4 within it (raster)
- mv_x_i  in  MV_W  signed candidate MV x
- mv_y_i  in  MV_W  signed candidate MV y
- busy_o  out  1  search in progress
- done_o  out  1  1-cycle pulse, results valid
- best_sad_o  out  PART_NUM*SADP_LEN  packed minima; field order: 8x8[0..3], 16x8 top, 16x8 bot, 8x16 left, 8x16 right, 16x16
- best_mv_o  out  PART_NUM*2*MV_W  packed {mv_y,mv_x} per partition, same order

Behaviour:
- Reset: the interface is one clock (clk) with asynchronous active-low reset (rstn). While rstn=0:
  - state=IDLE.
  - busy_o=0, done_o=0.
  - best_sad_o=0, best_mv_o=0.
  - Both pipeline valids=0.
  - Reset mid-search abandons the search; no done_o is produced.
- FSM states: IDLE, SEARCH, DRAIN.
  - IDLE: start_i -> SEARCH. Every best SAD is set to all-ones (2^SADP_LEN-1) and every best MV to 0 in that cycle. busy_o=1 from the next cycle.
  - SEARCH: valid_i&&last_i -> DRAIN. valid_i without last_i stays in SEARCH.
  - DRAIN: waits until stage-2 has consumed the last beat, then pulses done_o for 1 cycle -> IDLE. busy_o=0 in the same cycle done_o=1.
- Ignored inputs:
  - valid_i is ignored in IDLE and DRAIN.
  - start_i is ignored in SEARCH and DRAIN.
  - last_i without valid_i is ignored.
- Pipeline, stage 1 (registered): sad8x8[i] = sum of sad4x4[4i..4i+3], then:
  - 16x8 top = 8x8[0]+[1]; 16x8 bottom = [2]+[3].
  - 8x16 left = [0]+[2]; 8x16 right = [1]+[3].
  - 16x16 = sum of all four 8x8.
  - All sums are zero-extended to SADP_LEN with no saturation (width guarantees no overflow).
  - The MV is registered alongside the sums.
- Pipeline, stage 2 (registered): per partition, if merged < best then update best SAD and MV.
  - Strict less-than, so on ties the earliest candidate wins.
- Latency: the candidate accepted at cycle t affects best_* at t+2. done_o asserts at t+2 after the last beat, when best_* already include it.
- Throughput: one candidate per cycle; back-to-back valid_i is allowed. No backpressure is required.
- best_*_o hold their values after done_o until the next start_i.
- A window where last_i arrives on the first beat (single candidate) is legal. The result is that candidate's SADs.
- A start_i coinciding with done_o (state DRAIN) is ignored. The producer must wait one cycle.

Decomposition:
- Shared defines header (existing enc_defines): SAD4X4_LEN, SAD4X4_NUM, PART_NUM, MV_W, partition field index constants (P8X8_0..P16X16).
- Sub-module ime_sad_merge: combinational 16 -> 9 partition adder tree. Stage-1 registers live in the parent.
- Compare/update is replicated 9x via generate in the parent.

Test Plan:
- Single candidate: all sad4x4=1, mv=(3,-2), start then valid+last.
  - done_o exactly 2 cycles after the beat.
  - 8x8=4, 16x8/8x16=8, 16x16=16; all mvs (3,-2).
- Three back-to-back candidates with all-uniform 4x4 values 10, 5, 7 and mv (0,0), (1,1), (2,2).
  - Every partition best = 5*(#4x4s) with mv (1,1).
- Tie: two candidates with identical SADs=20 and mvs (4,0) then (-4,0).
  - All winners keep mv (4,0).
- Per-partition independence: cand A has only block i=0 4x4s=0 (others 100); cand B has i=3 4x4s=0 (others 100).
  - 8x8[0] -> A, 8x8[3] -> B, 16x16 = 1200 for both so A wins, 16x8 top -> A, 16x8 bot -> B.
- Max value: all sad4x4=4080.
  - 16x16=65280 with no wrap.
  - 16x8=32640.
- Reset mid-SEARCH after 2 beats: outputs 0, no done_o. New start plus one beat of 2s gives 16x16=32.
  - Also: valid_i in IDLE changes nothing, and start_i during SEARCH does not reinit.
